// File: rtl/rs_pkg.sv
// rs_pkg: types shared by the reservation stations: FSM states, compare op codes, entry layout.
package rs_pkg;
  localparam int RS_TAG_W = 5;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} rs_state_t;
  typedef enum logic [2:0] {
    CMP_NONE = 3'd0, CMP_EQ = 3'd1, CMP_NE = 3'd2, CMP_LT = 3'd3,
    CMP_GE = 3'd4, CMP_LTU = 3'd5, CMP_GEU = 3'd6
  } rs_cmp_t;
  typedef struct packed {
    logic rdy;
    logic [RS_TAG_W-1:0] tag;
    logic [31:0] data;
  } rs_opnd_t;
  typedef struct packed {
    logic valid;
    logic jalr;
    logic [3:0] cmp_ctrl;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [RS_TAG_W-1:0] rd_tag;
    rs_opnd_t rs1;
    rs_opnd_t rs2;
  } rs_entry_t;
  typedef struct packed {
    logic valid;
    logic rdy;
    logic jalr;
    logic [3:0] cmp_ctrl;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [RS_TAG_W-1:0] rd_tag;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } rs_head_t;
  function automatic rs_opnd_t rs_wake(input rs_opnd_t o, input logic v,
                                       input logic [RS_TAG_W-1:0] t, input logic [31:0] d);
    rs_wake = o;
    if (v && !o.rdy && o.tag == t) begin
      rs_wake.rdy = 1'b1;
      rs_wake.data = d;
    end
  endfunction
endpackage

// File: rtl/rs_jump_entry.sv
// rs_jump_entry: one jump-station slot with CDB snoop and operand capture.
module rs_jump_entry
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr,
  input  logic                free,
  input  rs_entry_t           din,
  input  logic                cdb_valid,
  input  logic [RS_TAG_W-1:0] cdb_tag,
  input  logic [31:0]         cdb_data,
  output rs_head_t            q
);
  rs_entry_t e;
  // a dispatched operand also snoops the CDB so a same-cycle broadcast is not lost
  always_ff @(posedge clk)
    if (rst || clr) e <= '0;
    else if (wr) begin
      e <= din;
      e.rs1 <= rs_wake(din.rs1, cdb_valid, cdb_tag, cdb_data);
      e.rs2 <= rs_wake(din.rs2, cdb_valid, cdb_tag, cdb_data);
    end else if (free) e.valid <= 1'b0;
    else if (e.valid) begin
      e.rs1 <= rs_wake(e.rs1, cdb_valid, cdb_tag, cdb_data);
      e.rs2 <= rs_wake(e.rs2, cdb_valid, cdb_tag, cdb_data);
    end
  assign q = '{valid: e.valid, rdy: e.rs1.rdy && e.rs2.rdy, jalr: e.jalr, cmp_ctrl: e.cmp_ctrl,
               pc: e.pc, imm: e.imm, rd_tag: e.rd_tag, rs1_data: e.rs1.data, rs2_data: e.rs2.data};
endmodule

// File: rtl/rs_jump.sv
// rs_jump: in-order reservation station feeding the branch/jump FU.
module rs_jump
  import rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = RS_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic             disp_jalr,
  input  logic [3:0]       disp_cmp_ctrl,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_rs1_data,
  input  logic [31:0]      disp_rs2_data,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             disp_rs1_rdy,
  input  logic             disp_rs2_rdy,
  input  logic [TAG_W-1:0] disp_rd_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             fu_en,
  output logic             fu_jalr,
  output logic [3:0]       fu_cmp_ctrl,
  output logic [31:0]      fu_rs1_data,
  output logic [31:0]      fu_rs2_data,
  output logic [31:0]      fu_imm,
  output logic [31:0]      fu_pc,
  input  logic             fu_finish,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  rs_state_t state;
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  rs_head_t ent [DEPTH];
  rs_head_t h;
  rs_entry_t din;
  logic issue, push;
  assign h = ent[head];
  assign disp_ready = count != FULL;
  assign empty = count == '0;
  assign issue = state == S_IDLE && h.valid && h.rdy && !flush;
  assign push = disp_valid && disp_ready && !flush;
  assign fu_en = issue;
  assign fu_jalr = h.jalr;
  assign fu_cmp_ctrl = h.cmp_ctrl;
  assign fu_pc = h.pc;
  assign fu_imm = h.imm;
  assign fu_rs1_data = h.rs1_data;
  assign fu_rs2_data = h.rs2_data;
  assign res_valid = state == S_WAIT && fu_finish && !flush;
  assign din = '{valid: 1'b1, jalr: disp_jalr, cmp_ctrl: disp_cmp_ctrl, pc: disp_pc, imm: disp_imm,
                 rd_tag: disp_rd_tag,
                 rs1: '{rdy: disp_rs1_rdy, tag: disp_rs1_tag, data: disp_rs1_data},
                 rs2: '{rdy: disp_rs2_rdy, tag: disp_rs2_tag, data: disp_rs2_data}};
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rs_jump_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .wr        (push && tail == PW'(i)),
      .free      (issue && head == PW'(i)),
      .din       (din),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .q         (ent[i])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      res_tag <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(issue);
      tail <= tail + PW'(push);
      count <= count + (PW+1)'(push) - (PW+1)'(issue);
      state <= state == S_IDLE ? (issue ? S_WAIT : S_IDLE) : (fu_finish ? S_IDLE : S_WAIT);
      if (issue) res_tag <= h.rd_tag;
    end
endmodule

// File: doc/rs_jump.md
# rs_jump

In-order reservation station for the branch/jump functional unit. Accepts branch/JAL/JALR micro-ops from dispatch, captures missing source operands from the common data bus (CDB), and issues the oldest entry to the jump FU once both operands are present. Follows the FU's single-pulse EN / one-cycle finish protocol and tags each result for writeback and redirect logic.

## Interface
- DEPTH, 4 — entry count; power of two, ≥2
- TAG_W, 5 — rename/ROB tag width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  mispredict squash; empties the station
- disp_valid  in  1  dispatch offers a micro-op
- disp_ready  out  1  station can accept (not full)
- disp_jalr  in  1  JALR flag
- disp_cmp_ctrl  in  4  [3:1] compare op (EQ=1, NE=2, LT=3, GE=4, LTU=5, GEU=6); [0] unconditional jump
- disp_pc, disp_imm  in  32 each  instruction PC, sign-extended immediate
- disp_rs1_data, disp_rs2_data  in  32 each  operand value when ready
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  producer tag when not ready
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  operand valid (dispatch drives 1 for unused operands)
- disp_rd_tag  in  TAG_W  destination tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  32  broadcast value
- fu_en  out  1  one-cycle issue pulse to FU
- fu_jalr, fu_cmp_ctrl, fu_rs1_data, fu_rs2_data, fu_imm, fu_pc  out  1/4/32/32/32/32  head-entry fields
- fu_finish  in  1  FU result valid
- res_valid  out  1  tagged result valid (fu_finish & ~flush)
- res_tag  out  TAG_W  rd tag of the finishing op
- empty  out  1  no valid entries

## Operation
- Circular buffer; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits. Entry: valid, jalr, cmp_ctrl, pc, imm, rd_tag, rs1 {rdy,tag,data}, rs2 {rdy,tag,data}.
- Dispatch: disp_valid & disp_ready writes the tail entry and advances tail. disp_ready = (count != DEPTH); no credit for a same-cycle issue.
- Wakeup: every valid entry with rsN_rdy=0 and rsN_tag==cdb_tag while cdb_valid captures cdb_data and sets rdy. A dispatched operand whose tag matches the same-cycle CDB is written as ready with cdb_data.
- FSM: IDLE, WAIT.
  - IDLE: head valid, both rdy flags set, and ~flush -> fu_en=1; head entry freed and head advanced on that edge; rd_tag latched into res_tag; -> WAIT.
  - WAIT: fu_en=0; fu_finish -> IDLE. WAIT lasts exactly one cycle.
- Issue only from the head; a younger ready entry never bypasses the head.
- fu_* data outputs are driven combinationally from the head entry, not gated.
- flush: clears all valid bits, head=tail=count=0, FSM -> IDLE. It blocks issue and dispatch in the same cycle and suppresses res_valid.
- Operand readiness is registered. A CDB wakeup in cycle t makes the entry issuable in cycle t+1.

## Timing
- Reset values:
  - fu_en=0, res_valid=0, res_tag=0
  - disp_ready=1, empty=1
  - fu_* data=0 (all entry storage is reset)
  - FSM=IDLE
- Dispatch to issue with both operands ready: disp at edge t, fu_en high in cycle t+1.
- Issue to result: fu_en in cycle n, fu_finish/res_valid in cycle n+1. Peak throughput is 1 op per 2 cycles.
- Simultaneous events:
  - Dispatch into a full station is refused.
  - Dispatch and issue in the same cycle: both proceed; count unchanged.
  - CDB wakeup of the head and issue in the same cycle: the issue waits one cycle.
  - Flush together with anything: flush wins.
- fu_finish arriving in IDLE is ignored; res_valid is not asserted.
- rst mid-operation behaves identically to reset from power-up.

## Structure
- Shared package rs_pkg holds:
  - FSM state encodings (IDLE=0, WAIT=1)
  - cmp_ctrl op codes
  - the entry field layout, shared with the other reservation stations
- Sub-module rs_jump_entry: one entry's storage plus CDB compare/capture logic, instantiated DEPTH times. Top level holds the pointers, count, and FSM.

## Test plan
- Ready BEQ (rs1=rs2=7, pc=0x100, imm=0x20, rd_tag=3) -> fu_en next cycle with fu_cmp_ctrl=0b0010; finish one cycle later; res_valid=1, res_tag=3.
- JALR with rs1 pending on tag 9; CDB tag 9 data 0x2000 three cycles later -> fu_en exactly one cycle after the broadcast; fu_rs1_data=0x2000.
- Fill 4 entries with head blocked on tag 5 -> disp_ready=0; CDB tag 5 -> head issues; disp_ready returns to 1 the cycle after.
- Head not ready, entry 1 ready -> no fu_en until the head wakes; issue order is head then entry 1, at least 2 cycles apart.
- Flush in the WAIT cycle with 2 entries queued -> res_valid=0, empty=1 next cycle, no further fu_en.
- Dispatch with rs2 tag equal to the same-cycle CDB tag (data 0xDEAD) -> entry ready; issued fu_rs2_data=0xDEAD.
